// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with one byte-enabled synchronous write port and a
// combinational read on the same address. Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  // One independent array per byte lane so each enable gates only its lane.
  for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Define DMEM_RESPONDER_ERR_EN to flag misaligned / out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [BYTE_LANES-1:0] req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  dmem_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic        accept;
  logic        addr_err;
  logic        mem_we;
  logic [29:0] word_full;
  logic [AW-1:0] word_idx;
  logic [31:0] mem_rdata;

  assign word_full = req_addr[31:2];

`ifdef DMEM_RESPONDER_ERR_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (word_full >= 30'(DEPTH_WORDS));
  assign word_idx = word_full[AW-1:0];
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr[1:0];
  assign addr_err = 1'b0;
  assign word_idx = AW'(word_full % 30'(DEPTH_WORDS));
`endif

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign req_ready  = reset_n && (state_reg == IDLE);
  assign accept     = req_valid && req_ready;
  assign mem_we     = accept && req_write && !addr_err;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (req_be),
    .addr  (word_idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          // Load data is snapshotted here so later stores cannot change it.
          cnt_next   = LAT_LOAD;
          state_next = (LATENCY == 1) ? RESP : WAIT;
          rdata_next = (req_write || addr_err) ? 32'd0 : mem_rdata;
          err_next   = addr_err;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
          rdata_next = 32'd0;
          err_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance A (LATENCY=2) for directed tests, instance B
// (LATENCY=1) for back-to-back loads.
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_resp_ready = 1'b1;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_be = '0;
  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b1;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  exp_t qa[$];
  exp_t qb[$];

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor A: latency on rise, stability while stalled, data on handshake.
  logic        a_prev_valid = 1'b0;
  logic [31:0] a_held_rdata;
  logic        a_held_err;
  exp_t        a_pop;
  always @(negedge clk) begin
    if (!reset_n) begin
      a_prev_valid = 1'b0;
    end else begin
      if (a_resp_valid) begin
        check("a_ready_in_resp", 32'(a_req_ready), 32'd0);
        if (!a_prev_valid) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_resp: got rdata %h, required no response", a_resp_rdata);
          end else begin
            check("a_latency", 32'(cyc - qa[0].acc), 32'(LAT_A));
          end
          a_held_rdata = a_resp_rdata;
          a_held_err   = a_resp_err;
        end else begin
          check("a_hold_rdata", a_resp_rdata, a_held_rdata);
          check("a_hold_err", 32'(a_resp_err), 32'(a_held_err));
        end
        if (a_resp_ready && qa.size() > 0) begin
          a_pop = qa.pop_front();
          $display("A resp cyc=%0d rdata=%h err=%0d (exp %h/%0d)", cyc, a_resp_rdata, a_resp_err, a_pop.rdata, a_pop.err);
          check("a_rdata", a_resp_rdata, a_pop.rdata);
          check("a_err", 32'(a_resp_err), 32'(a_pop.err));
        end
      end
      a_prev_valid = a_resp_valid;
    end
  end

  // Monitor B: same checks with LATENCY=1.
  logic b_prev_valid = 1'b0;
  int   b_resp_cnt = 0;
  exp_t b_pop;
  always @(negedge clk) begin
    if (!reset_n) begin
      b_prev_valid = 1'b0;
    end else begin
      if (b_resp_valid) begin
        check("b_ready_in_resp", 32'(b_req_ready), 32'd0);
        if (!b_prev_valid) begin
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_resp: got rdata %h, required no response", b_resp_rdata);
          end else begin
            check("b_latency", 32'(cyc - qb[0].acc), 32'(LAT_B));
          end
        end
        if (b_resp_ready && qb.size() > 0) begin
          b_pop = qb.pop_front();
          b_resp_cnt++;
          $display("B resp cyc=%0d rdata=%h err=%0d (exp %h/%0d)", cyc, b_resp_rdata, b_resp_err, b_pop.rdata, b_pop.err);
          check("b_rdata", b_resp_rdata, b_pop.rdata);
          check("b_err", 32'(b_resp_err), 32'(b_pop.err));
        end
      end
      b_prev_valid = b_resp_valid;
    end
  end

  task automatic issue_a(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_rd,
                         input logic exp_err, input bit wait_done);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
    a_req_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_req_ready) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: req_ready %0d after %0d cycles, required 1", a_req_ready, n);
      a_req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd; e.err = exp_err; e.acc = cyc;
    qa.push_back(e);
    $display("A req  cyc=%0d %s addr=%h wdata=%h be=%b", cyc, w ? "ST" : "LD", addr, wd, be);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (qa.size() != 0 && n < 50) begin @(negedge clk); n++; end
      if (qa.size() != 0) begin
        checks++; errors++;
        $display("FAIL a_resp_timeout: %0d responses pending, required 0", qa.size());
        qa.delete();
      end
    end
  endtask

  logic        b_w     [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] b_addr  [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0};
  logic [31:0] b_wd    [5] = '{32'h01020304, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_exp   [5] = '{32'h0, 32'h0, 32'h01020304, 32'hA5A5A5A5, 32'h01020304};

  initial begin
    int   n;
    int   last_acc;
    exp_t e;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_a_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_a_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_a_resp_rdata", a_resp_rdata, 32'd0);
    check("rst_a_resp_err", 32'(a_resp_err), 32'd0);
    check("rst_b_req_ready", 32'(b_req_ready), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_a_req_ready", 32'(a_req_ready), 32'd1);
    check("post_rst_b_req_ready", 32'(b_req_ready), 32'd1);

    // Full store, load back, partial store, zero-enable store
    issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1);
    issue_a(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1'b1);
    issue_a(1'b1, 32'h10, 32'h12345678, 4'b0000, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1'b1);
    issue_a(1'b1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 1'b0, 1'b1);
    issue_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0110, 32'h0, 1'b0, 1'b1);

    // Load stalled by resp_ready=0 for 5 cycles
    a_resp_ready = 1'b0;
    issue_a(1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BBCC44, 1'b0, 1'b0);
    n = 0;
    while (!a_resp_valid && n < 20) begin @(negedge clk); n++; end
    check("hold_resp_valid_seen", 32'(a_resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", 32'(a_resp_valid), 32'd1);
      check("hold_req_ready", 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 a_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_after_valid", 32'(a_resp_valid), 32'd0);
    check("hold_after_ready", 32'(a_req_ready), 32'd1);
    check("hold_queue_drained", 32'(qa.size()), 32'd0);

    // Error flagging or address wrap, depending on build
    issue_a(1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 1'b1);
`ifdef DMEM_RESPONDER_ERR_EN
    issue_a(1'b0, 32'h13, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
    issue_a(1'b1, 32'h400, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, 1'b1);
    issue_a(1'b0, 32'h0, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 1'b1);
`else
    issue_a(1'b0, 32'h13, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1'b1);
    issue_a(1'b1, 32'h400, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 1'b1);
    issue_a(1'b0, 32'h0, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0, 1'b1);
`endif

    // Reset while in WAIT discards the load; memory survives
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1'b0);
    reset_n = 1'b0;
    qa.delete();
    @(negedge clk);
    check("wait_rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("wait_rst_req_ready", 32'(a_req_ready), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("wait_rel_req_ready", 32'(a_req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("wait_rel_no_resp", 32'(a_resp_valid), 32'd0);
      @(negedge clk);
    end
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEAA, 1'b0, 1'b1);

    // LATENCY=1 back-to-back stream with req_valid held high
    @(posedge clk); #1;
    b_req_valid = 1'b1;
    b_req_be    = 4'b1111;
    last_acc    = 0;
    for (int i = 0; i < 5; i++) begin
      b_req_write = b_w[i]; b_req_addr = b_addr[i]; b_req_wdata = b_wd[i];
      @(negedge clk);
      n = 0;
      while (!b_req_ready && n < 10) begin @(negedge clk); n++; end
      if (!b_req_ready) begin
        checks++; errors++;
        $display("FAIL b_accept_timeout: req_ready %0d at op %0d, required 1", b_req_ready, i);
        break;
      end
      e.rdata = b_exp[i]; e.err = 1'b0; e.acc = cyc;
      qb.push_back(e);
      $display("B req  cyc=%0d %s addr=%h wdata=%h", cyc, b_w[i] ? "ST" : "LD", b_addr[i], b_wd[i]);
      if (i > 0) check("b_accept_spacing", 32'(cyc - last_acc), 32'd2);
      last_acc = cyc;
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
    n = 0;
    while (qb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("b_resp_count", 32'(b_resp_cnt), 32'd5);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the memory.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to resp_valid; legal values are 1..15.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1, SHALL signal that the core presents a request.
REQ-006 Port req_ready, output, 1, SHALL signal that the responder can accept a request this cycle.
REQ-007 Port req_write, input, 1, SHALL be 1 for a store and 0 for a load.
REQ-008 Port req_addr, input, 32, SHALL be the byte address.
REQ-009 Port req_wdata, input, 32, SHALL be the store data.
REQ-010 Port req_be, input, 4, SHALL be the store byte enables; bit i covers wdata[8i+7:8i].
REQ-011 Port resp_valid, output, 1, SHALL signal that a response is presented.
REQ-012 Port resp_ready, input, 1, SHALL signal that the core accepts the response.
REQ-013 Port resp_rdata, output, 32, SHALL carry the load data; it is 0 for stores and errors.
REQ-014 Port resp_err, output, 1, SHALL flag an erroneous access.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP, and SHALL handle one outstanding request at most.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid && req_ready.
REQ-018 On accept, a store SHALL write the enabled bytes of word req_addr[31:2] on that edge.
REQ-019 On accept, a load SHALL capture the word into an internal register on that edge, so later stores cannot alter it.
REQ-020 Accept SHALL load a latency counter with LATENCY-1 and move to WAIT; if LATENCY==1, it moves directly to RESP.
REQ-021 WAIT SHALL decrement the counter each cycle and move to RESP when the counter is 0, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready is 1.
REQ-023 The RESP-to-IDLE transition SHALL occur on the edge where resp_ready is 1; resp_valid is 0 in the following cycle.
REQ-024 The earliest next accept after a response handshake SHALL be the cycle after it (no same-cycle turnaround).
REQ-025 resp_ready asserted outside RESP SHALL be ignored.
REQ-026 A store with req_be==4'b0000 SHALL still complete with a response and SHALL modify no data.

Reset
REQ-027 While reset_n=0, the block SHALL be in state IDLE with counter=0, resp_valid=0, resp_rdata=0, resp_err=0 and req_ready=0.
REQ-028 req_ready SHALL become 1 in the first cycle after reset_n deasserts.
REQ-029 Reset in WAIT or RESP SHALL discard the pending response.
REQ-030 A store already accepted before a reset SHALL remain committed, and memory contents SHALL not be reset.

Configuration
REQ-031 With DMEM_RESPONDER_ERR_EN defined, resp_err SHALL be 1 when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS, and such a request SHALL not access memory and SHALL return rdata 0 with normal latency.
REQ-032 With DMEM_RESPONDER_ERR_EN undefined, resp_err SHALL be tied 0, addr[1:0] SHALL be ignored, and the word index SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-033 The state enum typedef (IDLE/WAIT/RESP) and the byte-lane constant (4) SHALL live in package dmem_pkg.
REQ-034 Sub-module dmem_array SHALL hold the storage, with synchronous byte-enabled write and combinational read, parameterised by DEPTH_WORDS.

Verification
REQ-035 The bench SHALL cover: LATENCY=2, store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> resp_valid exactly 2 cycles after each accept, and the load returns 0xDEADBEEF.
REQ-036 The bench SHALL cover: store 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-037 The bench SHALL cover: a load held with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable and req_ready=0 throughout; IDLE follows the handshake edge.
REQ-038 The bench SHALL cover, with ERR_EN and DEPTH_WORDS=256: load 0x13 -> resp_err=1, rdata=0; store to 0x400 -> resp_err=1 and word 0 unchanged.
REQ-039 The bench SHALL cover: reset_n pulsed low while in WAIT after a load -> no resp_valid, and req_ready=1 in the cycle after release.
REQ-040 The bench SHALL cover: LATENCY=1 with back-to-back loads and resp_ready held 1 -> alternating accept and response cycles, one response per request.
